// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and sizing defaults for the padding streamer
package conv_pkg;
   localparam int PadBitsDefault = 4;
   localparam int CntW = 15;
   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;
endpackage

// File: rtl/conv_padding_streamer_if.sv
// conv_padding_streamer_if: upstream and downstream valid/ready stream signals
interface conv_padding_streamer_if #(
   parameter int N = 16
);
   logic [N-1:0] s_data_i;
   logic         s_valid_i;
   logic         s_ready_o;
   logic [N-1:0] m_data_o;
   logic         m_valid_o;
   logic         m_ready_i;
   modport slave (input s_data_i, s_valid_i, m_ready_i, output s_ready_o, m_data_o, m_valid_o);
   modport master (output s_data_i, s_valid_i, m_ready_i, input s_ready_o, m_data_o, m_valid_o);
endinterface

// File: rtl/conv_padding_streamer_raster_counter.sv
// raster_counter: row/col walk over a square grid, col fastest, with wrap and last flag
module raster_counter
   import conv_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            adv_i,
   input  logic [CntW-1:0] last_idx_i,
   output logic [CntW-1:0] row_o,
   output logic [CntW-1:0] col_o,
   output logic            last_o
);
   logic [CntW-1:0] row_q, row_d, col_q, col_d;
   // next grid position; both indices wrap to 0 after the final cell
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr_i) begin
         row_d = '0;
         col_d = '0;
      end else if (adv_i) begin
         col_d = (col_q == last_idx_i) ? '0 : col_q + 1'b1;
         if (col_q == last_idx_i) row_d = (row_q == last_idx_i) ? '0 : row_q + 1'b1;
      end
   end
   // position registers
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end
   assign row_o  = row_q;
   assign col_o  = col_q;
   assign last_o = (row_q == last_idx_i) && (col_q == last_idx_i);
endmodule

// File: rtl/conv_padding_streamer.sv
// conv_padding_streamer: wraps a raster MxM activation stream with a p-wide constant border
module conv_padding_streamer
   import conv_pkg::*;
#(
   parameter int MaxMatrixSize = 16383,
   parameter int N             = 16,
   parameter int PadBits       = PadBitsDefault
)(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [13:0]        matrix_size_i,
   input  logic [PadBits-1:0] padding_i,
   input  logic [N-1:0]       pad_value_i,
   conv_padding_streamer_if.slave bus,
   output logic               busy_o,
   output logic               done_o,
   output logic               cfg_err_o
);
   state_e             state_q, state_d;
   logic [13:0]        m_q, m_d;
   logic [PadBits-1:0] p_q, p_d;
   logic [N-1:0]       pad_q, pad_d, data_q, data_d;
   logic               valid_q, valid_d, done_q, done_d, err_q, err_d;
   logic [CntW-1:0]    last_q, last_d, size_req, row, col, lo, hi;
   logic               cnt_last, cnt_clr, cnt_adv, interior, load_ok, cfg_ok;

   assign size_req = CntW'(matrix_size_i) + (CntW'(padding_i) << 1);
   assign cfg_ok   = (matrix_size_i != '0) && (int'(size_req) <= MaxMatrixSize);
   assign lo       = CntW'(p_q);
   assign hi       = lo + CntW'(m_q);
   assign interior = (row >= lo) && (row < hi) && (col >= lo) && (col < hi);
   assign load_ok  = !valid_q || bus.m_ready_i;

   raster_counter u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (cnt_clr),
      .adv_i      (cnt_adv),
      .last_idx_i (last_q),
      .row_o      (row),
      .col_o      (col),
      .last_o     (cnt_last)
   );

   // next state: border cells load freely, interior cells wait for upstream data
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      p_d     = p_q;
      pad_d   = pad_q;
      last_d  = last_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      err_d   = err_q;
      cnt_clr = 1'b0;
      cnt_adv = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && cfg_ok) begin
               state_d = STREAM;
               m_d     = matrix_size_i;
               p_d     = padding_i;
               pad_d   = pad_value_i;
               last_d  = size_req - 1'b1;
               err_d   = 1'b0;
               cnt_clr = 1'b1;
            end else if (start_i) begin
               err_d = 1'b1;
            end
         end
         STREAM: begin
            if (load_ok && (!interior || bus.s_valid_i)) begin
               data_d  = interior ? bus.s_data_i : pad_q;
               valid_d = 1'b1;
               cnt_adv = 1'b1;
               state_d = cnt_last ? FLUSH : STREAM;
            end else if (bus.m_ready_i) begin
               valid_d = 1'b0;
            end
         end
         FLUSH: begin
            if (valid_q && bus.m_ready_i) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, configuration and output registers
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         m_q     <= '0;
         p_q     <= '0;
         pad_q   <= '0;
         last_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         p_q     <= p_d;
         pad_q   <= pad_d;
         last_q  <= last_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // ready is masked in reset so no word is lost in a reset cycle
   assign bus.s_ready_o = rst_i && (state_q == STREAM) && interior && load_ok;
   assign bus.m_data_o  = data_q;
   assign bus.m_valid_o = valid_q;
   assign busy_o        = state_q != IDLE;
   assign done_o        = done_q;
   assign cfg_err_o     = err_q;
endmodule

// File: tb/tb_conv_padding_streamer.sv
// tb_conv_padding_streamer: directed self-checking bench for the padding streamer
module tb_conv_padding_streamer;
   logic        clk = 1'b0;
   logic        rst_i, start_i;
   logic [13:0] matrix_size_i;
   logic [3:0]  padding_i;
   logic [15:0] pad_value_i;
   logic        busy_o, done_o, cfg_err_o;
   logic [15:0] exp_q[$];
   int          tests = 0;
   int          fails = 0;

   conv_padding_streamer_if #(.N(16)) bus ();

   conv_padding_streamer #(.MaxMatrixSize(16383), .N(16), .PadBits(4)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .matrix_size_i (matrix_size_i),
      .padding_i     (padding_i),
      .pad_value_i   (pad_value_i),
      .bus           (bus),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .cfg_err_o     (cfg_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int m, input int p, input logic [15:0] pad, input int base);
      int k = 0;
      exp_q.delete();
      for (int r = 0; r < m + 2 * p; r++)
         for (int c = 0; c < m + 2 * p; c++)
            if (r >= p && r < p + m && c >= p && c < p + m) begin
               exp_q.push_back(16'(base + k));
               k++;
            end else exp_q.push_back(pad);
   endtask

   task automatic run(input string tag, input int m, input int p, input logic [15:0] pad,
                      input bit rnd, input int base, input int stop_at, input bit poke);
      int nout = 0, nin = 0, done_cnt = 0, first_hs = -1, last_hs = -10;
      logic stalled = 1'b0;
      logic [15:0] held = '0;
      @(negedge clk);
      start_i = 1'b1; matrix_size_i = 14'(m); padding_i = 4'(p); pad_value_i = pad;
      @(negedge clk);
      start_i = 1'b0; matrix_size_i = '0; padding_i = '0; pad_value_i = 16'h5A5A;
      #1;
      check({tag, "_busy"}, busy_o, 1);
      check({tag, "_cfg_err"}, cfg_err_o, 0);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bus.m_ready_i = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         bus.s_valid_i = (nin < m * m) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
         bus.s_data_i  = 16'(base + nin);
         start_i       = poke && cyc == 5;
         matrix_size_i = poke ? 14'd1 : 14'd0;
         #1;
         if (done_o) begin
            done_cnt++;
            check({tag, "_done_at"}, cyc, last_hs + 1);
         end
         if (stalled) begin
            check({tag, "_hold_v"}, bus.m_valid_o, 1);
            check({tag, "_hold_d"}, bus.m_data_o, held);
         end
         if (bus.m_valid_o && bus.m_ready_i) begin
            if (nout < exp_q.size()) check({tag, "_data"}, bus.m_data_o, exp_q[nout]);
            else check({tag, "_extra_out"}, nout, exp_q.size());
            if (first_hs < 0) first_hs = cyc;
            nout++;
            last_hs = cyc;
         end
         stalled = bus.m_valid_o && !bus.m_ready_i;
         held = bus.m_data_o;
         if (bus.s_valid_i && bus.s_ready_o) nin++;
         if (stop_at > 0 && nout == stop_at) break;
         if (done_cnt > 0 && cyc >= last_hs + 3) break;
         @(negedge clk);
      end
      start_i = 1'b0;
      bus.s_valid_i = 1'b0;
      if (stop_at == 0) begin
         check({tag, "_out_cnt"}, nout, exp_q.size());
         check({tag, "_in_cnt"}, nin, m * m);
         check({tag, "_done_cnt"}, done_cnt, 1);
         check({tag, "_idle"}, busy_o, 0);
         if (!rnd) check({tag, "_rate"}, last_hs - first_hs, exp_q.size() - 1);
      end else check({tag, "_stop"}, nout, stop_at);
   endtask

   initial begin
      rst_i = 1'b0; start_i = 1'b0; matrix_size_i = '0; padding_i = '0; pad_value_i = '0;
      bus.s_data_i = '0; bus.s_valid_i = 1'b0; bus.m_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", bus.m_valid_o, 0);
      check("rst_data", bus.m_data_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", cfg_err_o, 0);
      check("rst_ready", bus.s_ready_o, 0);
      @(negedge clk);
      rst_i = 1'b1;

      exp_q = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                16'd0, 16'd1, 16'd2, 16'd3, 16'd0,
                16'd0, 16'd4, 16'd5, 16'd6, 16'd0,
                16'd0, 16'd7, 16'd8, 16'd9, 16'd0,
                16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
      run("m3p1", 3, 1, 16'd0, 1'b0, 1, 0, 1'b0);

      exp_q = '{16'd5, 16'd6, 16'd7, 16'd8};
      run("m2p0", 2, 0, 16'd0, 1'b0, 5, 0, 1'b0);

      fill(3, 2, 16'hFFFF, 100);
      run("m3p2rnd", 3, 2, 16'hFFFF, 1'b1, 100, 0, 1'b0);

      fill(3, 1, 16'h0007, 20);
      run("pre_rst", 3, 1, 16'h0007, 1'b0, 20, 7, 1'b0);
      @(negedge clk);
      rst_i = 1'b0; bus.s_valid_i = 1'b1; bus.m_ready_i = 1'b1;
      #1;
      check("rst_cycle_ready", bus.s_ready_o, 0);
      @(negedge clk);
      rst_i = 1'b1; bus.s_valid_i = 1'b0;
      #1;
      check("mid_rst_valid", bus.m_valid_o, 0);
      check("mid_rst_data", bus.m_data_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_done", done_o, 0);
      check("mid_rst_err", cfg_err_o, 0);
      fill(3, 1, 16'h0007, 20);
      run("post_rst", 3, 1, 16'h0007, 1'b0, 20, 0, 1'b0);

      @(negedge clk);
      start_i = 1'b1; matrix_size_i = 14'd0; padding_i = 4'd1;
      @(negedge clk);
      start_i = 1'b0;
      #1;
      check("m0_err", cfg_err_o, 1);
      check("m0_busy", busy_o, 0);

      fill(2, 1, 16'h0003, 50);
      run("poke", 2, 1, 16'h0003, 1'b0, 50, 0, 1'b1);

      @(negedge clk);
      start_i = 1'b1; matrix_size_i = 14'd16383; padding_i = 4'd1; bus.s_valid_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      #1;
      check("big_err", cfg_err_o, 1);
      check("big_busy", busy_o, 0);
      check("big_ready", bus.s_ready_o, 0);
      @(negedge clk);
      start_i = 1'b1; matrix_size_i = 14'd16382; padding_i = 4'd1;
      @(negedge clk);
      start_i = 1'b0; bus.s_valid_i = 1'b0;
      #1;
      check("edge_err", cfg_err_o, 1);
      check("edge_busy", busy_o, 0);

      fill(2, 1, 16'h0009, 70);
      run("recover", 2, 1, 16'h0009, 1'b0, 70, 0, 1'b0);
      check("recover_err", cfg_err_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/conv_padding_streamer.md
CONV_PADDING_STREAMER -- requirements
Module: conv_padding_streamer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  MaxMatrixSize, 16383, largest padded matrix edge accepted.
  N, 16, data word width.
  PadBits, 4, padding field width.
REQ-002 clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-low.
REQ-004 start_i  input  1  single-cycle request to start one padded matrix stream.
REQ-005 matrix_size_i  input  14  unpadded edge length M.
REQ-006 padding_i  input  PadBits  border width p.
REQ-007 pad_value_i  input  N  signed value emitted in border positions.
REQ-008 s_data_i  input  N  raw activation word, raster order.
REQ-009 s_valid_i  input  1  s_data_i valid.
REQ-010 s_ready_o  output  1  upstream word accepted when s_valid_i&&s_ready_o.
REQ-011 m_data_o  output  N  padded activation word (feeds convolution activation input).
REQ-012 m_valid_o  output  1  m_data_o valid.
REQ-013 m_ready_i  input  1  downstream accepts when m_valid_o&&m_ready_i.
REQ-014 busy_o  output  1  stream in progress.
REQ-015 done_o  output  1  one-cycle pulse after final word handshakes.
REQ-016 cfg_err_o  output  1  sticky: last start rejected for bad configuration.

Function
REQ-017 FSM states SHALL be IDLE, STREAM, FLUSH; busy_o=1 in STREAM and FLUSH.
REQ-018 IDLE->STREAM on start_i when M>0 and P=M+2p <= MaxMatrixSize; M, p, pad_value SHALL be latched then; cfg_err_o cleared.
REQ-019 start_i with M=0 or P>MaxMatrixSize SHALL leave FSM in IDLE and set cfg_err_o; start_i while busy SHALL be ignored.
REQ-020 Raster counters row,col (15 bits each, 0..P-1) SHALL walk the padded grid, col fastest.
REQ-021 Position is interior iff p<=row<p+M and p<=col<p+M; otherwise border.
REQ-022 Output register SHALL load when (!m_valid_o || m_ready_i); counters advance only on load.
REQ-023 Border load SHALL occur without s_valid_i, with m_data_o=latched pad_value.
REQ-024 Interior load SHALL require s_valid_i; s_ready_o = STREAM && interior && (!m_valid_o || m_ready_i); m_data_o=s_data_i.
REQ-025 Interior with s_valid_i=0: no load; m_valid_o drops after current word is taken.
REQ-026 Latency: loaded word SHALL appear on m_data_o the next cycle; sustained throughput one word/cycle.
REQ-027 Loading position (P-1,P-1) SHALL move STREAM->FLUSH; FLUSH->IDLE on its handshake, with done_o=1 that cycle+1 only.
REQ-028 Exactly P*P output and M*M input handshakes per stream; no loss, duplication or reordering under any stall pattern.
REQ-029 m_data_o, m_valid_o SHALL hold stable while m_valid_o && !m_ready_i.
REQ-030 p=0 SHALL be pure pass-through of M*M words.

Reset
REQ-031 rst_i=0 at a clock edge SHALL force IDLE, counters 0, m_data_o=0, m_valid_o=0, s_ready_o=0, busy_o=0, done_o=0, cfg_err_o=0, including mid-stream; partial data discarded.
REQ-032 No upstream word SHALL be accepted in a reset cycle.

Structure
REQ-033 Shared package conv_pkg SHALL hold the FSM state enum and PadBits default.
REQ-034 One sub-module, raster_counter (row/col pair with wrap and last flag), is natural; remaining logic inline.

Verification
REQ-035 M=3,p=1,pad=0, inputs 1..9, m_ready=1 -> 25 words: 0,0,0,0,0 / 0,1,2,3,0 / 0,4,5,6,0 / 0,7,8,9,0 / 0,0,0,0,0; done_o one cycle after 25th handshake.
REQ-036 M=2,p=0, inputs 5,6,7,8 -> outputs 5,6,7,8, done_o pulses once.
REQ-037 M=3,p=2,pad=-1, m_ready_i random 50%, s_valid_i random gaps -> 49 words, border=-1, interior in order, data held stable while stalled.
REQ-038 rst_i=0 after 7 outputs -> all outputs zero next cycle; new start streams full 25 words correctly.
REQ-039 M=16383,p=1 -> cfg_err_o=1, busy_o=0, s_ready_o=0; subsequent valid start clears cfg_err_o.
REQ-040 start_i asserted mid-stream -> ignored; output count unchanged.
